// File: rtl/debug_hart_pkg.sv
// Shared types and constants for the debug hart stub: FSM state encoding,
// abstract register numbers and dcsr helpers.
package debug_hart_pkg;

    typedef enum logic [2:0] {
        ST_RUNNING,
        ST_HALTING,
        ST_HALTED,
        ST_RESUMING,
        ST_RESET
    } hart_state_e;

    localparam logic [15:0] AR_GPR_BASE = 16'h1000;
    localparam logic [15:0] AR_MISA     = 16'h0301;
    localparam logic [15:0] AR_DCSR     = 16'h07B0;
    localparam logic [15:0] AR_DPC      = 16'h07B1;
    localparam logic [15:0] AR_MHARTID  = 16'h0F14;

    localparam logic [31:0] DCSR_RESET = 32'h4000_0003;
    // ebreakm, step and prv are the only debugger-writable dcsr fields
    localparam logic [31:0] DCSR_WMASK = 32'h0000_8007;

    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

    function automatic logic [31:0] dcsr_set_cause(input logic [31:0] d, input logic [2:0] c);
        return {d[31:9], c, d[5:0]};
    endfunction

    function automatic logic [31:0] dcsr_write(input logic [31:0] old, input logic [31:0] w);
        return (old & ~DCSR_WMASK) | (w & DCSR_WMASK);
    endfunction

endpackage

// File: rtl/debug_hart_stub_if.sv
// Abstract register access bus between the debug module (master) and the hart stub (slave).
interface debug_hart_stub_if #(parameter int HW = 2);
    logic          AR_EN;
    logic          AR_WR;
    logic [HW-1:0] AR_HART;
    logic [15:0]   AR_AD;
    logic [31:0]   AR_WDATA;
    logic [31:0]   AR_RDATA;
    logic          AR_ACK;
    logic          AR_ERR;

    modport master (output AR_EN, AR_WR, AR_HART, AR_AD, AR_WDATA,
                    input  AR_RDATA, AR_ACK, AR_ERR);
    modport slave  (input  AR_EN, AR_WR, AR_HART, AR_AD, AR_WDATA,
                    output AR_RDATA, AR_ACK, AR_ERR);
endinterface

// File: rtl/debug_hart_fsm.sv
// One modelled hart: halt/resume/reset handshake FSM with latency counter,
// sticky flags and the debug CSRs dcsr/dpc. Request inputs are already synchronised.
module debug_hart_fsm
    import debug_hart_pkg::*;
#(
    parameter int HALT_LAT = 2
) (
    input  logic        CLK100MHZ,
    input  logic        TRST_N,
    input  logic        haltreq,
    input  logic        resumereq,
    input  logic        hartreset,
    input  logic        ackhavereset,
    input  logic        dcsr_we,
    input  logic        dpc_we,
    input  logic [31:0] wdata,
    output logic        halted,
    output logic        running,
    output logic        resumeack,
    output logic        havereset,
    output logic [31:0] dcsr,
    output logic [31:0] dpc
);

    localparam logic [3:0] LAT_LOAD = (HALT_LAT == 0) ? 4'd0 : 4'(HALT_LAT - 1);

    hart_state_e state;
    logic [3:0]  cnt;
    logic        ack_r;
    logic        havereset_r;

    always_ff @(posedge CLK100MHZ or negedge TRST_N) begin
        if (!TRST_N) begin
            state       <= ST_RUNNING;
            cnt         <= '0;
            ack_r       <= 1'b0;
            havereset_r <= 1'b1;
            dcsr        <= DCSR_RESET;
            dpc         <= '0;
            halted      <= 1'b0;
            running     <= 1'b1;
            resumeack   <= 1'b0;
            havereset   <= 1'b1;
        end else begin
            // output stage: visible flags trail the internal state by one cycle
            halted    <= (state == ST_HALTED);
            running   <= (state == ST_RUNNING);
            resumeack <= ack_r;
            havereset <= havereset_r;

            if (hartreset)         havereset_r <= 1'b1;
            else if (ackhavereset) havereset_r <= 1'b0;

            if (!resumereq) ack_r <= 1'b0;
            if (dcsr_we)    dcsr  <= dcsr_write(dcsr, wdata);
            if (dpc_we)     dpc   <= wdata;

            if (hartreset) begin
                state <= ST_RESET;
                dcsr  <= DCSR_RESET;
                dpc   <= '0;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (haltreq) begin
                            state <= ST_HALTED;
                            dcsr  <= dcsr_set_cause(DCSR_RESET, CAUSE_RESETHALT);
                        end else begin
                            state <= ST_RUNNING;
                        end
                    end
                    ST_RUNNING: begin
                        if (haltreq && HALT_LAT == 0) begin
                            state <= ST_HALTED;
                            dcsr  <= dcsr_set_cause(dcsr, CAUSE_HALTREQ);
                        end else if (haltreq) begin
                            state <= ST_HALTING;
                            cnt   <= LAT_LOAD;
                        end
                    end
                    ST_HALTING: begin
                        if (cnt == 4'd0) begin
                            state <= ST_HALTED;
                            dcsr  <= dcsr_set_cause(dcsr, CAUSE_HALTREQ);
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    ST_HALTED: begin
                        // a pending halt request, or an unacknowledged previous resume, blocks resuming
                        if (resumereq && !haltreq && !ack_r) begin
                            if (HALT_LAT == 0) begin
                                state <= ST_RUNNING;
                                ack_r <= 1'b1;
                            end else begin
                                state <= ST_RESUMING;
                                cnt   <= LAT_LOAD;
                            end
                        end
                    end
                    ST_RESUMING: begin
                        if (cnt == 4'd0) begin
                            state <= ST_RUNNING;
                            ack_r <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: state <= ST_RUNNING;
                endcase
            end
        end
    end

endmodule

// File: rtl/debug_hart_stub.sv
// Multi-hart target model behind the debug module: request synchronisers,
// per-hart FSMs, GPR file and the registered abstract-register access port.
module debug_hart_stub
    import debug_hart_pkg::*;
#(
    parameter int          NHARTS   = 4,
    parameter int          HALT_LAT = 2,
    parameter logic [31:0] MISA     = 32'h4000_1105,
    parameter int          HW       = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic              CLK100MHZ,
    input  logic              TRST_N,
    input  logic [NHARTS-1:0] HALTREQ,
    input  logic [NHARTS-1:0] RESUMEREQ,
    input  logic [NHARTS-1:0] HARTRESET,
    input  logic [NHARTS-1:0] ACKHAVERESET,
    output logic [NHARTS-1:0] HALTED,
    output logic [NHARTS-1:0] RUNNING,
    output logic [NHARTS-1:0] RESUMEACK,
    output logic [NHARTS-1:0] HAVERESET,
    debug_hart_stub_if.slave  ar,
    output logic [3:0]        LED
);

    localparam int AW = HW + 5;

    logic [NHARTS-1:0] haltreq_p0, haltreq_p1, resumereq_p0, resumereq_p1;
    logic [NHARTS-1:0] hartreset_p0, hartreset_p1, ackhr_p0, ackhr_p1;

    // stage 0/1: two-flop synchronisers from the TCK domain
    always_ff @(posedge CLK100MHZ or negedge TRST_N) begin
        if (!TRST_N) begin
            haltreq_p0   <= '0;
            haltreq_p1   <= '0;
            resumereq_p0 <= '0;
            resumereq_p1 <= '0;
            hartreset_p0 <= '0;
            hartreset_p1 <= '0;
            ackhr_p0     <= '0;
            ackhr_p1     <= '0;
        end else begin
            haltreq_p0   <= HALTREQ;
            haltreq_p1   <= haltreq_p0;
            resumereq_p0 <= RESUMEREQ;
            resumereq_p1 <= resumereq_p0;
            hartreset_p0 <= HARTRESET;
            hartreset_p1 <= hartreset_p0;
            ackhr_p0     <= ACKHAVERESET;
            ackhr_p1     <= ackhr_p0;
        end
    end

    logic          hart_ok, is_gpr, mapped, acc_err, wr_ok, gpr_we;
    logic [HW-1:0] hidx;
    logic [AW-1:0] gaddr;
    logic [31:0]   rd_mux;
    logic [31:0]   dcsr_h [NHARTS];
    logic [31:0]   dpc_h  [NHARTS];
    logic [NHARTS-1:0] dcsr_we, dpc_we;

    for (genvar i = 0; i < NHARTS; i++) begin : g_hart
        assign dcsr_we[i] = wr_ok && (ar.AR_AD == AR_DCSR) && (hidx == HW'(i));
        assign dpc_we[i]  = wr_ok && (ar.AR_AD == AR_DPC)  && (hidx == HW'(i));

        debug_hart_fsm #(.HALT_LAT(HALT_LAT)) u_fsm (
            .CLK100MHZ    (CLK100MHZ),
            .TRST_N       (TRST_N),
            .haltreq      (haltreq_p1[i]),
            .resumereq    (resumereq_p1[i]),
            .hartreset    (hartreset_p1[i]),
            .ackhavereset (ackhr_p1[i]),
            .dcsr_we      (dcsr_we[i]),
            .dpc_we       (dpc_we[i]),
            .wdata        (ar.AR_WDATA),
            .halted       (HALTED[i]),
            .running      (RUNNING[i]),
            .resumeack    (RESUMEACK[i]),
            .havereset    (HAVERESET[i]),
            .dcsr         (dcsr_h[i]),
            .dpc          (dpc_h[i])
        );
    end

    // GPR storage has no reset; a per-entry written flag makes unwritten registers read 0
    logic [31:0]          gpr_mem [NHARTS*32];
    logic [NHARTS*32-1:0] gpr_vld;

    always_comb begin
        hart_ok = int'(ar.AR_HART) < NHARTS;
        hidx    = hart_ok ? ar.AR_HART : '0;
        gaddr   = {hidx, ar.AR_AD[4:0]};
        is_gpr  = (ar.AR_AD[15:5] == AR_GPR_BASE[15:5]);
        mapped  = is_gpr || (ar.AR_AD inside {AR_MISA, AR_DCSR, AR_DPC, AR_MHARTID});
        acc_err = !hart_ok || !HALTED[hidx] || !mapped;
        wr_ok   = ar.AR_EN && ar.AR_WR && !acc_err;
        gpr_we  = wr_ok && is_gpr && (ar.AR_AD[4:0] != 5'd0);
        rd_mux  = '0;
        if (is_gpr) begin
            rd_mux = gpr_vld[gaddr] ? gpr_mem[gaddr] : '0;
        end else begin
            case (ar.AR_AD)
                AR_MISA:    rd_mux = MISA;
                AR_DCSR:    rd_mux = dcsr_h[hidx];
                AR_DPC:     rd_mux = dpc_h[hidx];
                AR_MHARTID: rd_mux = 32'(hidx);
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (gpr_we) gpr_mem[gaddr] <= ar.AR_WDATA;
    end

    logic        ack_p1, err_p1, led_err_p1;
    logic [31:0] rdata_p1;

    // stage 1: registered access response
    always_ff @(posedge CLK100MHZ or negedge TRST_N) begin
        if (!TRST_N) begin
            ack_p1     <= 1'b0;
            err_p1     <= 1'b0;
            rdata_p1   <= '0;
            led_err_p1 <= 1'b0;
            gpr_vld    <= '0;
        end else begin
            ack_p1     <= ar.AR_EN;
            err_p1     <= ar.AR_EN && acc_err;
            led_err_p1 <= led_err_p1 || (ar.AR_EN && acc_err);
            if (ar.AR_EN) rdata_p1 <= acc_err ? '0 : rd_mux;
            if (gpr_we)   gpr_vld[gaddr] <= 1'b1;
        end
    end

    assign ar.AR_ACK   = ack_p1;
    assign ar.AR_ERR   = err_p1;
    assign ar.AR_RDATA = rdata_p1;
    assign LED         = {led_err_p1, |HAVERESET, |HALTED, |RESUMEACK};

endmodule

// File: tb/tb_debug_hart_stub.sv
// Directed bench for debug_hart_stub: 4-hart instance with HALT_LAT=2 plus a
// 3-hart HALT_LAT=0 instance for the out-of-range hart and zero-latency cases.
module tb_debug_hart_stub;

    logic       CLK100MHZ = 1'b0;
    logic       TRST_N    = 1'b0;
    logic [3:0] HALTREQ, RESUMEREQ, HARTRESET, ACKHAVERESET;
    logic [3:0] HALTED, RUNNING, RESUMEACK, HAVERESET, LED;
    logic [2:0] HALTREQ3, RESUMEREQ3, HARTRESET3, ACKHAVERESET3;
    logic [2:0] HALTED3, RUNNING3, RESUMEACK3, HAVERESET3;
    logic [3:0] LED3;

    int n_checks = 0;
    int n_fail   = 0;

    debug_hart_stub_if #(.HW(2)) ar_if ();
    debug_hart_stub_if #(.HW(2)) ar3_if ();

    debug_hart_stub #(.NHARTS(4), .HALT_LAT(2), .MISA(32'h4000_1105)) u_dut (
        .CLK100MHZ (CLK100MHZ), .TRST_N (TRST_N),
        .HALTREQ (HALTREQ), .RESUMEREQ (RESUMEREQ), .HARTRESET (HARTRESET), .ACKHAVERESET (ACKHAVERESET),
        .HALTED (HALTED), .RUNNING (RUNNING), .RESUMEACK (RESUMEACK), .HAVERESET (HAVERESET),
        .ar (ar_if), .LED (LED)
    );

    debug_hart_stub #(.NHARTS(3), .HALT_LAT(0), .MISA(32'h4000_1105)) u_dut3 (
        .CLK100MHZ (CLK100MHZ), .TRST_N (TRST_N),
        .HALTREQ (HALTREQ3), .RESUMEREQ (RESUMEREQ3), .HARTRESET (HARTRESET3), .ACKHAVERESET (ACKHAVERESET3),
        .HALTED (HALTED3), .RUNNING (RUNNING3), .RESUMEACK (RESUMEACK3), .HAVERESET (HAVERESET3),
        .ar (ar3_if), .LED (LED3)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // one abstract access on the selected instance; response sampled after the strobe edge
    task automatic ar_xfer(input bit sel, input logic wr, input logic [1:0] hart, input logic [15:0] ad,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err);
        if (!sel) begin
            ar_if.AR_EN = 1'b1; ar_if.AR_WR = wr; ar_if.AR_HART = hart; ar_if.AR_AD = ad; ar_if.AR_WDATA = wd;
            tick();
            check("ar_ack", 32'(ar_if.AR_ACK), 32'd1);
            rd = ar_if.AR_RDATA; err = ar_if.AR_ERR;
            ar_if.AR_EN = 1'b0;
        end else begin
            ar3_if.AR_EN = 1'b1; ar3_if.AR_WR = wr; ar3_if.AR_HART = hart; ar3_if.AR_AD = ad; ar3_if.AR_WDATA = wd;
            tick();
            check("ar3_ack", 32'(ar3_if.AR_ACK), 32'd1);
            rd = ar3_if.AR_RDATA; err = ar3_if.AR_ERR;
            ar3_if.AR_EN = 1'b0;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        HALTREQ = '0; RESUMEREQ = '0; HARTRESET = '0; ACKHAVERESET = '0;
        HALTREQ3 = '0; RESUMEREQ3 = '0; HARTRESET3 = '0; ACKHAVERESET3 = '0;
        ar_if.AR_EN = 0; ar_if.AR_WR = 0; ar_if.AR_HART = '0; ar_if.AR_AD = '0; ar_if.AR_WDATA = '0;
        ar3_if.AR_EN = 0; ar3_if.AR_WR = 0; ar3_if.AR_HART = '0; ar3_if.AR_AD = '0; ar3_if.AR_WDATA = '0;

        // reset values
        tick(3);
        TRST_N = 1'b1;
        tick();
        check("rst_running",   32'(RUNNING),   32'hF);
        check("rst_halted",    32'(HALTED),    32'h0);
        check("rst_resumeack", 32'(RESUMEACK), 32'h0);
        check("rst_havereset", 32'(HAVERESET), 32'hF);
        check("rst_led",       32'(LED),       32'h4);
        check("rst_ack",       32'(ar_if.AR_ACK),  32'd0);
        check("rst_err",       32'(ar_if.AR_ERR),  32'd0);
        check("rst_rdata",     ar_if.AR_RDATA,     32'd0);

        // ACKHAVERESET clears HAVERESET three edges after being sampled
        ACKHAVERESET = 4'hF;
        tick(3);
        check("ackhr_edge2", 32'(HAVERESET), 32'hF);
        tick();
        check("ackhr_edge3", 32'(HAVERESET), 32'h0);
        ACKHAVERESET = '0;
        check("ackhr_led", 32'(LED), 32'h0);

        // one-cycle halt request on hart 1: HALTED at edge 3+HALT_LAT
        HALTREQ[1] = 1'b1;
        tick();
        HALTREQ[1] = 1'b0;
        tick(4);
        check("halt_edge4", 32'(HALTED), 32'h0);
        tick();
        check("halt_edge5", 32'(HALTED), 32'h2);
        ar_xfer(0, 0, 2'd1, 16'h07B0, 32'd0, rd, err);
        check("h1_dcsr", rd, 32'h4000_00C3);
        check("h1_dcsr_err", 32'(err), 32'd0);

        // resume hart 1
        RESUMEREQ[1] = 1'b1;
        tick(5);
        check("resume_edge4", 32'(RESUMEACK), 32'h0);
        tick();
        check("resume_edge5", 32'(RESUMEACK), 32'h2);
        check("resume_halted", 32'(HALTED), 32'h0);
        check("resume_running", 32'(RUNNING), 32'hF);
        check("resume_led", 32'(LED), 32'h1);
        RESUMEREQ[1] = 1'b0;
        tick(3);
        check("rack_edge2", 32'(RESUMEACK), 32'h2);
        tick();
        check("rack_edge3", 32'(RESUMEACK), 32'h0);

        // halt hart 2 for register access
        HALTREQ[2] = 1'b1;
        tick(2);
        HALTREQ[2] = 1'b0;
        tick(6);
        check("h2_halted", 32'(HALTED), 32'h4);
        ar_xfer(0, 1, 2'd2, 16'h1005, 32'hDEAD_BEEF, rd, err);
        check("x5_wr_err", 32'(err), 32'd0);
        ar_xfer(0, 0, 2'd2, 16'h1005, 32'd0, rd, err);
        check("x5_rd", rd, 32'hDEAD_BEEF);
        check("x5_rd_err", 32'(err), 32'd0);
        ar_xfer(0, 1, 2'd2, 16'h1000, 32'hFFFF_FFFF, rd, err);
        check("x0_wr_err", 32'(err), 32'd0);
        ar_xfer(0, 0, 2'd2, 16'h1000, 32'd0, rd, err);
        check("x0_rd", rd, 32'd0);
        ar_xfer(0, 0, 2'd2, 16'h1006, 32'd0, rd, err);
        check("x6_unwritten", rd, 32'd0);
        ar_xfer(0, 0, 2'd2, 16'h0F14, 32'd0, rd, err);
        check("mhartid", rd, 32'd2);
        ar_xfer(0, 1, 2'd2, 16'h0301, 32'd0, rd, err);
        check("misa_wr_err", 32'(err), 32'd0);
        ar_xfer(0, 0, 2'd2, 16'h0301, 32'd0, rd, err);
        check("misa_rd", rd, 32'h4000_1105);
        ar_xfer(0, 1, 2'd2, 16'h07B0, 32'hFFFF_FFFF, rd, err);
        ar_xfer(0, 0, 2'd2, 16'h07B0, 32'd0, rd, err);
        check("dcsr_mask", rd, 32'h4000_80C7);
        ar_xfer(0, 1, 2'd2, 16'h07B1, 32'h8000_0100, rd, err);
        ar_xfer(0, 0, 2'd2, 16'h07B1, 32'd0, rd, err);
        check("dpc_rw", rd, 32'h8000_0100);
        tick();
        check("ack_pulse", 32'(ar_if.AR_ACK), 32'd0);

        // error cases
        ar_xfer(0, 0, 2'd0, 16'h1005, 32'd0, rd, err);
        check("running_err", 32'(err), 32'd1);
        check("running_rdata", rd, 32'd0);
        check("err_led", 32'(LED), 32'hA);
        ar_xfer(0, 0, 2'd2, 16'h0200, 32'd0, rd, err);
        check("unmapped_err", 32'(err), 32'd1);
        check("unmapped_rdata", rd, 32'd0);
        ar_xfer(0, 1, 2'd3, 16'h1007, 32'h0000_1111, rd, err);
        check("rej_wr_err", 32'(err), 32'd1);
        ar_xfer(0, 1, 2'd2, 16'h07B2, 32'h0000_2222, rd, err);
        check("unmapped_wr_err", 32'(err), 32'd1);
        ar_xfer(0, 0, 2'd2, 16'h1005, 32'd0, rd, err);
        check("x5_after_err", rd, 32'hDEAD_BEEF);
        check("x5_after_err_ok", 32'(err), 32'd0);
        check("led3_sticky", 32'(LED[3]), 32'd1);

        // halt wins over resume on a halted hart
        HALTREQ[2] = 1'b1; RESUMEREQ[2] = 1'b1;
        tick(8);
        check("both_halted", 32'(HALTED), 32'h4);
        check("both_noack", 32'(RESUMEACK), 32'h0);
        HALTREQ[2] = 1'b0; RESUMEREQ[2] = 1'b0;
        tick(4);
        check("both_release", 32'(HALTED), 32'h4);

        // hart reset during HALTING, released with HALTREQ still high
        HALTREQ[3] = 1'b1;
        tick();
        HARTRESET[3] = 1'b1;
        tick(5);
        check("hr_halted", 32'(HALTED), 32'h4);
        check("hr_running", 32'(RUNNING), 32'h3);
        check("hr_havereset", 32'(HAVERESET), 32'h8);
        tick(3);
        check("hr_held", 32'(HALTED), 32'h4);
        HARTRESET[3] = 1'b0;
        tick(5);
        check("hr_rel_halted", 32'(HALTED), 32'hC);
        check("hr_rel_havereset", 32'(HAVERESET), 32'h8);
        HALTREQ[3] = 1'b0;
        ar_xfer(0, 0, 2'd3, 16'h07B0, 32'd0, rd, err);
        check("h3_dcsr_cause5", rd, 32'h4000_0143);
        ar_xfer(0, 0, 2'd3, 16'h1007, 32'd0, rd, err);
        check("h3_x7_unchanged", rd, 32'd0);
        check("h3_x7_err", 32'(err), 32'd0);
        ar_xfer(0, 0, 2'd3, 16'h07B1, 32'd0, rd, err);
        check("h3_dpc", rd, 32'd0);
        check("final_led", 32'(LED), 32'hE);

        // 3-hart instance, HALT_LAT=0: direct halt, then out-of-range hart index
        check("d3_havereset", 32'(HAVERESET3), 32'h7);
        HALTREQ3 = 3'b111;
        tick(3);
        check("d3_halt_edge2", 32'(HALTED3), 32'h0);
        tick();
        check("d3_halt_edge3", 32'(HALTED3), 32'h7);
        check("d3_running", 32'(RUNNING3), 32'h0);
        check("d3_resumeack", 32'(RESUMEACK3), 32'h0);
        ar_xfer(1, 0, 2'd3, 16'h0F14, 32'd0, rd, err);
        check("d3_range_err", 32'(err), 32'd1);
        check("d3_range_rdata", rd, 32'd0);
        ar_xfer(1, 0, 2'd2, 16'h0F14, 32'd0, rd, err);
        check("d3_mhartid", rd, 32'd2);
        check("d3_mhartid_err", 32'(err), 32'd0);
        check("d3_led", 32'(LED3), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
